// File: rtl/cfg_wr_arb.sv
// Two-requester round-robin arbiter for the configuration-register write port.
// Requester A (UART) is barred from a protected address window and can be locked out by the CPU.
module cfg_wr_arb #(
  parameter int            AW        = 8,
  parameter int            DW        = 8,
  parameter logic [AW-1:0] PROT_BASE = 8'hF0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_dat,
  output logic          a_busy,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_dat,
  output logic          b_busy,
  input  logic          lock,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_dat,
  output logic          wr_id,
  input  logic          wr_rdy,
  output logic          a_ovf,
  output logic          a_perr,
  output logic          b_ovf,
  input  logic          err_clr
);

  typedef enum logic {IDLE, ISSUE} state_t;

  localparam logic ID_A = 1'b0;
  localparam logic ID_B = 1'b1;

  state_t        state;
  logic          last;
  logic          pend_a, pend_b;
  logic [AW-1:0] a_addr_q, b_addr_q;
  logic [DW-1:0] a_dat_q, b_dat_q;

  logic xfer, xfer_a, xfer_b;
  logic a_prot, a_free, b_free;
  logic a_cap, a_drop, b_cap, b_drop;
  logic elig_a, elig_b;
  logic sel_valid, sel_id;

  // A buffer is also free while its own entry is being accepted, so a back-to-back
  // strobe from the same requester refills it without loss.
  assign xfer   = wr_en && wr_rdy;
  assign xfer_a = xfer && (wr_id == ID_A);
  assign xfer_b = xfer && (wr_id == ID_B);

  assign a_prot = a_addr >= PROT_BASE;
  assign a_free = !pend_a || xfer_a;
  assign b_free = !pend_b || xfer_b;

  assign a_cap  = a_we && !a_prot && a_free;
  assign a_drop = a_we && !a_prot && !a_free;
  assign b_cap  = b_we && b_free;
  assign b_drop = b_we && !b_free;

  assign elig_a = pend_a && !lock;
  assign elig_b = pend_b;

  assign a_busy = pend_a;
  assign b_busy = pend_b;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    sel_valid = elig_a || elig_b;
    sel_id    = ID_A;
    if (elig_a && elig_b) sel_id = ~last;
    else if (elig_b)      sel_id = ID_B;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_a <= 1'b0;
      pend_b <= 1'b0;
    end else begin
      if (a_cap)       pend_a <= 1'b1;
      else if (xfer_a) pend_a <= 1'b0;
      if (b_cap)       pend_b <= 1'b1;
      else if (xfer_b) pend_b <= 1'b0;
    end
  end

  // NOTE: buffer payloads are not reset; they are only ever read while the matching pend bit is set.
  always_ff @(posedge clk) begin
    if (a_cap) begin
      a_addr_q <= a_addr;
      a_dat_q  <= a_dat;
    end
    if (b_cap) begin
      b_addr_q <= b_addr;
      b_dat_q  <= b_dat;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      last    <= ID_B;
      wr_en   <= 1'b0;
      wr_id   <= ID_A;
      wr_addr <= '0;
      wr_dat  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (sel_valid) begin
            wr_en   <= 1'b1;
            wr_id   <= sel_id;
            wr_addr <= (sel_id == ID_B) ? b_addr_q : a_addr_q;
            wr_dat  <= (sel_id == ID_B) ? b_dat_q  : a_dat_q;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          if (wr_rdy) begin
            wr_en <= 1'b0;
            last  <= wr_id;
            state <= IDLE;
          end
        end
        default: begin
          wr_en <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Setting a sticky flag wins over a coincident clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_ovf  <= 1'b0;
      a_perr <= 1'b0;
      b_ovf  <= 1'b0;
    end else begin
      if (a_drop)       a_ovf <= 1'b1;
      else if (err_clr) a_ovf <= 1'b0;
      if (a_we && a_prot) a_perr <= 1'b1;
      else if (err_clr)   a_perr <= 1'b0;
      if (b_drop)       b_ovf <= 1'b1;
      else if (err_clr) b_ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cfg_wr_arb.sv
// Directed self-checking bench for cfg_wr_arb: latency, round-robin, stall/refill,
// protected window, lock, sticky flags and asynchronous reset.
module tb_cfg_wr_arb;

  logic       clk = 1'b0;
  logic       reset;
  logic       a_we, b_we, lock, wr_rdy, err_clr;
  logic [7:0] a_addr, a_dat, b_addr, b_dat;
  logic       a_busy, b_busy, wr_en, wr_id, a_ovf, a_perr, b_ovf;
  logic [7:0] wr_addr, wr_dat;

  int n_assert = 0;
  int n_fail   = 0;

  logic       exp_id;
  logic [7:0] exp_a_addr, exp_a_dat, exp_b_addr, exp_b_dat;

  cfg_wr_arb dut (
    .clk     (clk),
    .reset   (reset),
    .a_we    (a_we),
    .a_addr  (a_addr),
    .a_dat   (a_dat),
    .a_busy  (a_busy),
    .b_we    (b_we),
    .b_addr  (b_addr),
    .b_dat   (b_dat),
    .b_busy  (b_busy),
    .lock    (lock),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_dat  (wr_dat),
    .wr_id   (wr_id),
    .wr_rdy  (wr_rdy),
    .a_ovf   (a_ovf),
    .a_perr  (a_perr),
    .b_ovf   (b_ovf),
    .err_clr (err_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; outputs are sampled and inputs driven here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    a_we = 0; b_we = 0; lock = 0; err_clr = 0; wr_rdy = 0;
    a_addr = 0; a_dat = 0; b_addr = 0; b_dat = 0;
    #2;
    @(negedge clk);
    reset = 1'b0;
    tick();
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_wr_en"}, wr_en, 0);
  endtask

  task automatic check_wr(input string tag, input logic id, input logic [7:0] ad, input logic [7:0] dt);
    check({tag, "_wr_en"}, wr_en, 1);
    check({tag, "_wr_id"}, wr_id, id);
    check({tag, "_wr_addr"}, wr_addr, ad);
    check({tag, "_wr_dat"}, wr_dat, dt);
  endtask

  initial begin
    do_reset();
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_id", wr_id, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_dat", wr_dat, 0);
    check("rst_busy", {a_busy, b_busy}, 0);
    check("rst_flags", {a_ovf, a_perr, b_ovf}, 0);

    // Single A write: busy in cycles 1-2, wr_en in cycle 2, done by cycle 3.
    a_we = 1; a_addr = 8'h12; a_dat = 8'h34; wr_rdy = 1;
    tick(); a_we = 0;
    check("s1_a_busy_c1", a_busy, 1);
    check_idle("s1_c1");
    tick();
    check("s1_a_busy_c2", a_busy, 1);
    check_wr("s1_c2", 0, 8'h12, 8'h34);
    tick();
    check_idle("s1_c3");
    check("s1_a_busy_c3", a_busy, 0);

    // Simultaneous A and B after reset, then keep both eligible by refilling on each transfer.
    do_reset();
    wr_rdy = 1;
    a_we = 1; a_addr = 8'h05; a_dat = 8'hAA;
    b_we = 1; b_addr = 8'h06; b_dat = 8'hBB;
    exp_a_addr = 8'h05; exp_a_dat = 8'hAA; exp_b_addr = 8'h06; exp_b_dat = 8'hBB;
    tick(); a_we = 0; b_we = 0;
    tick();
    exp_id = 0;
    check_wr("rr_first", exp_id, exp_a_addr, exp_a_dat);
    for (int k = 0; k < 4; k++) begin
      if (exp_id == 0) begin
        a_we = 1; a_addr = 8'h40 + 8'(k); a_dat = 8'hC0 + 8'(k);
        exp_a_addr = a_addr; exp_a_dat = a_dat;
      end else begin
        b_we = 1; b_addr = 8'h50 + 8'(k); b_dat = 8'hD0 + 8'(k);
        exp_b_addr = b_addr; exp_b_dat = b_dat;
      end
      tick(); a_we = 0; b_we = 0;
      check_idle("rr_gap");
      check("rr_refill_busy", {a_busy, b_busy}, 2'b11);
      tick();
      exp_id = ~exp_id;
      if (exp_id == 0) check_wr("rr_grant_a", 0, exp_a_addr, exp_a_dat);
      else             check_wr("rr_grant_b", 1, exp_b_addr, exp_b_dat);
    end

    // Stall with overflow, then refill in the transfer cycle.
    do_reset();
    wr_rdy = 0;
    b_we = 1; b_addr = 8'h20; b_dat = 8'h01;
    tick(); b_we = 0;
    check("st_b_busy", b_busy, 1);
    tick();
    check_wr("st_issue", 1, 8'h20, 8'h01);
    b_we = 1; b_addr = 8'h30; b_dat = 8'h99;
    tick(); b_we = 0;
    check("st_b_ovf", b_ovf, 1);
    for (int k = 0; k < 3; k++) begin
      check_wr("st_hold", 1, 8'h20, 8'h01);
      tick();
    end
    check_wr("st_hold_last", 1, 8'h20, 8'h01);
    wr_rdy = 1;
    b_we = 1; b_addr = 8'h21; b_dat = 8'h02;
    tick(); b_we = 0;
    check_idle("st_after_xfer");
    check("st_refill_busy", b_busy, 1);
    tick();
    check_wr("st_refill", 1, 8'h21, 8'h02);
    tick();
    check_idle("st_done");
    check("st_b_busy_done", b_busy, 0);
    err_clr = 1;
    tick(); err_clr = 0;
    check("st_b_ovf_clr", b_ovf, 0);

    // Protected window and lock.
    do_reset();
    wr_rdy = 1;
    a_we = 1; a_addr = 8'hF3; a_dat = 8'h77;
    tick(); a_we = 0;
    check("pr_a_perr", a_perr, 1);
    check("pr_a_busy", a_busy, 0);
    tick();
    check_idle("pr_no_write");
    lock = 1;
    a_we = 1; a_addr = 8'h10; a_dat = 8'h55;
    b_we = 1; b_addr = 8'h11; b_dat = 8'h66;
    tick(); a_we = 0; b_we = 0;
    check("lk_busy", {a_busy, b_busy}, 2'b11);
    tick();
    check_wr("lk_b_grant", 1, 8'h11, 8'h66);
    tick();
    check_idle("lk_b_done");
    check("lk_busy_after_b", {a_busy, b_busy}, 2'b10);
    tick();
    check_idle("lk_a_held");
    check("lk_a_busy_held", a_busy, 1);
    lock = 0;
    tick();
    check_wr("lk_a_grant", 0, 8'h10, 8'h55);
    tick();
    check("lk_a_busy_done", a_busy, 0);
    err_clr = 1;
    tick(); err_clr = 0;
    check("pr_perr_clr", a_perr, 0);
    err_clr = 1; a_we = 1; a_addr = 8'hF5; a_dat = 8'h00;
    tick(); err_clr = 0; a_we = 0;
    check("pr_perr_set_wins", a_perr, 1);
    check("pr_perr_no_busy", a_busy, 0);

    // Asynchronous reset while a write is stalled in ISSUE.
    do_reset();
    wr_rdy = 0;
    a_we = 1; a_addr = 8'h12; a_dat = 8'h34;
    b_we = 1; b_addr = 8'h13; b_dat = 8'h56;
    tick(); a_we = 0; b_we = 0;
    tick();
    check_wr("ar_issue", 0, 8'h12, 8'h34);
    b_we = 1; b_addr = 8'h14; b_dat = 8'h57;
    tick(); b_we = 0;
    check("ar_b_ovf", b_ovf, 1);
    #2;
    reset = 1'b1;
    #1;
    check("ar_wr_en", wr_en, 0);
    check("ar_busy", {a_busy, b_busy}, 0);
    check("ar_flags", {a_ovf, a_perr, b_ovf}, 0);
    @(negedge clk);
    reset = 1'b0;
    wr_rdy = 1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check_idle("ar_no_stale");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
